// File: rtl/seg_display_interface.sv
// +----------------------------------------------------------------------------+
// | seg_display_interface: source mux, double-dabble BCD engine, 7-seg panel.  |
// | Optional macro: LEADING_ZERO_BLANK_EN (blank leading value/index digits).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module seg_display_interface #(
  parameter int DATA_W          = 32,
  parameter int NUM_DIGITS      = 4,
  parameter int IDX_W           = 5,
  parameter int INDEX_MAX       = 9,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    Halt,
  input  logic                    Type,
  input  logic                    Swap,
  input  logic [DATA_W-1:0]       MonitorReg,
  input  logic [DATA_W-1:0]       Output,
  input  logic [DATA_W-1:0]       DataIO,
  output logic [IDX_W-1:0]        Indice,
  output logic [7*NUM_DIGITS-1:0] ValueSeg,
  output logic [13:0]             IndexSeg,
  output logic [6:0]              HaltSeg,
  output logic [6:0]              TypeSeg,
  output logic                    Overflow,
  output logic                    Busy,
  output logic                    Update
);

  localparam int BCD_DIGITS = (DATA_W + 2) / 3 + 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam int DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [IDX_W+3:0] TEN = (IDX_W + 4)'(10);
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LEAD_FILL = SEG_BLANK;
`else
  localparam logic [6:0] LEAD_FILL = SEG_ZERO;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [7*NUM_DIGITS-1:0] value_reset();
    logic [7*NUM_DIGITS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DIGITS; i++) v[7*i +: 7] = (i == 0) ? SEG_ZERO : LEAD_FILL;
    return v;
  endfunction

  localparam logic [7*NUM_DIGITS-1:0] VALUE_RST = value_reset();

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       sr_q, sr_d, src;
  logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7*NUM_DIGITS-1:0] value_seg_q, value_seg_d;
  logic                    overflow_q, overflow_d, ovf;
  logic                    busy_q, busy_d;
  logic                    update_q, update_d;
  logic [6:0]              halt_seg_q, halt_seg_d, type_seg_q, type_seg_d;
  logic [1:0]              sync_q, sync_d;
  logic                    deb_q, deb_d;
  logic [DB_W-1:0]         deb_cnt_q, deb_cnt_d;
  logic [IDX_W-1:0]        indice_q, indice_d;
  logic [13:0]             index_seg_q, index_seg_d;
  logic [IDX_W+3:0]        idx_wide;
  logic [3:0]              idx_tens, idx_units;
`ifdef LEADING_ZERO_BLANK_EN
  logic                    lead;
`endif

  // Conversion engine: IDLE capture, DATA_W add-3/shift steps, DONE publish.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    value_seg_d = value_seg_q;
    overflow_d  = overflow_q;
    busy_d      = busy_q;
    update_d    = 1'b0;
    src         = Halt ? DataIO : (Type ? Output : MonitorReg);
    bcd_adj     = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    ovf = 1'b0;
    for (int i = NUM_DIGITS; i < BCD_DIGITS; i++) ovf = ovf | (|bcd_q[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        sr_d    = src;
        bcd_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {bcd_d, sr_d} = {bcd_adj, sr_q} << 1;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        for (int i = 0; i < NUM_DIGITS; i++) value_seg_d[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        // An overflowing value has its leading digit off-display, so nothing is blanked.
        lead = ~ovf;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
          if (lead && (bcd_q[4*i +: 4] == 4'd0)) value_seg_d[7*i +: 7] = SEG_BLANK;
          else lead = 1'b0;
        end
`endif
        overflow_d = ovf;
        busy_d     = 1'b0;
        update_d   = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Panel side: status digits, Swap synchroniser/debouncer, index counter.
  always_comb begin
    halt_seg_d = seg7({3'b000, Halt});
    type_seg_d = seg7({3'b000, Type});
    sync_d     = {sync_q[0], Swap};
    deb_d      = deb_q;
    deb_cnt_d  = '0;
    if (sync_q[1] != deb_q) begin
      if (deb_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) deb_d = sync_q[1];
      else deb_cnt_d = deb_cnt_q + 1'b1;
    end
    indice_d = indice_q;
    if (deb_d && !deb_q) indice_d = (indice_q == IDX_W'(INDEX_MAX)) ? '0 : indice_q + 1'b1;
    idx_wide    = {4'b0000, indice_q};
    idx_tens    = 4'(idx_wide / TEN);
    idx_units   = 4'(idx_wide % TEN);
    index_seg_d = {seg7(idx_tens), seg7(idx_units)};
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_wide < TEN) index_seg_d[13:7] = SEG_BLANK;
`endif
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      value_seg_q <= VALUE_RST;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      update_q    <= 1'b0;
      halt_seg_q  <= SEG_ZERO;
      type_seg_q  <= SEG_ZERO;
      sync_q      <= '0;
      deb_q       <= 1'b0;
      deb_cnt_q   <= '0;
      indice_q    <= '0;
      index_seg_q <= {LEAD_FILL, SEG_ZERO};
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      value_seg_q <= value_seg_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      update_q    <= update_d;
      halt_seg_q  <= halt_seg_d;
      type_seg_q  <= type_seg_d;
      sync_q      <= sync_d;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      indice_q    <= indice_d;
      index_seg_q <= index_seg_d;
    end
  end

  assign Indice   = indice_q;
  assign ValueSeg = value_seg_q;
  assign IndexSeg = index_seg_q;
  assign HaltSeg  = halt_seg_q;
  assign TypeSeg  = type_seg_q;
  assign Overflow = overflow_q;
  assign Busy     = busy_q;
  assign Update   = update_q;

endmodule

`default_nettype wire

// File: doc/seg_display_interface.md
Name: seg_display_interface

Overview:
- Parametrised front-panel display block for the processor board.
- Selects one of three data sources (register monitor, program output, input data) and converts it to decimal with a sequential double-dabble engine.
- Drives NUM_DIGITS seven-segment digits, plus a debounced register-index selector and Halt/Type status digits.
- Sits between the datapath/control unit and the board displays; successor to the fixed 4-digit display interface.

Parameters:
- DATA_W, 32, width of the source words.
- NUM_DIGITS, 4, number of decimal digits driven on ValueSeg (1..10).
- IDX_W, 5, width of Indice.
- INDEX_MAX, 9, last index value before wrap to 0 (must be <= 99 and < 2**IDX_W).
- DEBOUNCE_CYCLES, 50000, number of consecutive stable cycles required to accept a new Swap level (>= 1).

Ports:
- Clock  in  1  system clock; all state is on its rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Halt  in  1  1 = show DataIO.
- Type  in  1  when Halt=0: 0 = MonitorReg, 1 = Output.
- Swap  in  1  raw push-button, asynchronous to Clock, active-high.
- MonitorReg  in  DATA_W  register-file monitor value.
- Output  in  DATA_W  program output value.
- DataIO  in  DATA_W  input data value.
- Indice  out  IDX_W  selected register index.
- ValueSeg  out  7*NUM_DIGITS  value digits; bits [6:0] are the least significant digit.
- IndexSeg  out  14  Indice as tens [13:7] and units [6:0].
- HaltSeg  out  7  digit showing Halt (0/1).
- TypeSeg  out  7  digit showing Type (0/1).
- Overflow  out  1  value has more than NUM_DIGITS decimal digits.
- Busy  out  1  conversion in progress.
- Update  out  1  one-cycle pulse when ValueSeg/Overflow are updated.

Behaviour:
- Segment code per digit, active-low, bit order {g,f,e,d,c,b,a}:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - Blank = 0x7F.
- Reset (Resetn=0, takes effect immediately):
  - FSM returns to IDLE; Indice=0.
  - ValueSeg shows all digits 0; IndexSeg shows 00; HaltSeg and TypeSeg show 0.
  - Overflow=0, Busy=0, Update=0.
  - Debouncer and synchroniser state are cleared to 0.
- Source mux, sampled only on the IDLE capture cycle:
  - Halt=1 → DataIO.
  - Halt=0, Type=0 → MonitorReg.
  - Halt=0, Type=1 → Output.
- FSM:
  - IDLE: capture the mux value into the shift register, clear the BCD accumulator, go to SHIFT, Busy=1.
  - SHIFT: for exactly DATA_W cycles, first add 3 to every BCD nibble >= 5, then shift {BCD, shift register} left by 1. The BCD accumulator holds ceil(DATA_W/3)+1 digits.
  - DONE: load ValueSeg from the low NUM_DIGITS nibbles. Overflow=1 if any higher nibble is nonzero. Update=1 for this cycle only, Busy=0, next state IDLE.
  - The engine is free-running: the refresh period is DATA_W+2 cycles.
  - Source or select changes during SHIFT are ignored until the next capture.
  - Displayed values change only in DONE.
- HaltSeg/TypeSeg: registered every cycle from Halt/Type (one-cycle latency).
- Swap:
  - Two-flop synchroniser, then debouncer. The debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A rising edge of the debounced level increments Indice once.
  - If Indice == INDEX_MAX, the increment wraps Indice to 0.
  - Holding the button produces no repeat increments.
- IndexSeg: tens = Indice/10, units = Indice%10. Registered; updates one cycle after Indice.
- Reset asserted mid-SHIFT aborts the conversion with no Update pulse. After release, conversion restarts from IDLE.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined: in DONE, every ValueSeg digit above the most significant nonzero digit is driven 0x7F. Digit 0 always shows a numeral, so a value of 0 shows a single "0". The IndexSeg tens digit is blank when Indice < 10. Reset shows only ValueSeg digit 0 as "0" and the rest blank.
- Not defined: all digits always show numerals, including leading zeros.

Test Plan:
- Settings: DATA_W=32, NUM_DIGITS=4, DEBOUNCE_CYCLES=4, INDEX_MAX=9, macro off unless stated.
- Reset: Resetn=0 → Indice=0, ValueSeg=0x40 in all 4 digits, IndexSeg={0x40,0x40}, Busy=0, Overflow=0.
- Monitor path: Halt=0, Type=0, MonitorReg=1234 → within 2 periods (68 cycles) an Update pulse, then ValueSeg digits 3..0 = 0x79,0x24,0x30,0x19 and Overflow=0. Busy high for exactly 33 cycles per period. With LEADING_ZERO_BLANK_EN and MonitorReg=7 → 0x7F,0x7F,0x7F,0x78.
- Halt path: Halt=1, DataIO=98765, Output=5 → digits 0x00,0x78,0x02,0x12 (8765), Overflow=1. Then Halt=0, Type=1 → digits 0x40,0x40,0x40,0x12, Overflow=0.
- Debounce: Swap high for 2 cycles → Indice unchanged. Swap high for 10 cycles with a 1-cycle bounce in the middle → Indice increments exactly once.
- Wrap: 10 clean presses from reset → Indice steps 1..9 then 0. At Indice=9, IndexSeg = {0x40,0x10}.
- Reset mid-operation: assert Resetn=0 during the 10th SHIFT cycle → Busy=0 immediately, outputs at reset values, no Update pulse. After release, the next Update shows the correct value.
